uart_rx_monitor: RTL and testbench
==================================

# uart_rx_monitor

Synthesizable, parametrised UART receive monitor that deserialises a TX line and checks the received byte stream against an expected message. It is the hardware successor of the bench-level UART monitor used for SoC bring-up. It sits on the SoC UART TX pin, either in simulation or on silicon for self-test. It reports per-frame data/errors and a sticky pass/fail verdict, and adds a configurable divisor, data width, stop bits, message length, terminator and optional parity.

## Interface
- CLK_FREQ_HZ, 100000000, io_systemClk frequency; DIV = CLK_FREQ_HZ/BAUD_RATE (truncated, must be ≥ 4), HALF = DIV/2.
- BAUD_RATE, 115200, line rate.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- STOP_BITS, 1, 1 or 2.
- MSG_LEN, 24, expected message length in characters, ≥ 1; CW = $clog2(MSG_LEN+1).
- TERM_CHAR, 'h21, terminator character; on receipt, the check completes.
- PARITY_ODD, 0, 1 = odd, 0 = even; used only with UART_RX_MON_PARITY_EN.
- io_systemClk  in  1  sole clock.
- io_asyncResetn  in  1  reset, asynchronous assert, active-low.
- rxd  in  1  UART line, asynchronous, idle high.
- check_en  in  1  0 holds checker cleared; 1 arms checking.
- expected_data  in  MSG_LEN*DATA_BITS  character j at [j*DATA_BITS +: DATA_BITS]; static while check_en=1.
- rx_valid  out  1  one-cycle pulse per completed frame.
- rx_data  out  DATA_BITS  last frame's data, held until the next frame.
- rx_frame_err  out  1  qualifies rx_valid: a stop bit was sampled as 0.
- rx_parity_err  out  1  qualifies rx_valid: parity mismatch.
- byte_count  out  CW  frames consumed by the checker, saturates at MSG_LEN.
- done  out  1  sticky: terminator received or MSG_LEN frames consumed.
- pass  out  1  done & ~fail.
- fail  out  1  sticky: first mismatch or frame/parity error.
- mismatch_index  out  CW  index of the first failing frame.

## Operation
- rxd passes through a 2-flop synchronizer (reset value 1) to give rxd_s. All sampling uses rxd_s.
- Receiver states are IDLE, START, DATA, PARITY (macro only), STOP and WAIT_HIGH. There is a single counter, baud_cnt.
- The `armed` flag resets to 0 and is set in IDLE when rxd_s=1.
- IDLE: when armed & rxd_s=0, go to START and load baud_cnt=0.
- START: at baud_cnt=HALF-1, sample. A 1 is a glitch: return to IDLE with no rx_valid. A 0 goes to DATA.
- DATA: sample every DIV cycles into a shift register, LSB first. After DATA_BITS samples, go to PARITY or STOP.
- PARITY: one sample; compare with the computed parity.
- STOP: take STOP_BITS samples, DIV apart. Any 0 sets frame_err.
- After the last stop sample, pulse rx_valid and update rx_data and the error outputs. Then go to IDLE (no error) or WAIT_HIGH (frame_err).
- WAIT_HIGH: on a break or line stuck low, clear `armed` and stay until rxd_s=1.
- Checker, while check_en=1 and done=0, on each rx_valid with index idx=byte_count:
  - On an error, or when rx_data ≠ expected_data[idx], and fail=0: set fail and mismatch_index=idx.
  - Then increment byte_count.
  - If rx_data==TERM_CHAR or byte_count reaches MSG_LEN: set done.
- Frames received after done are ignored by the checker but still reported on rx_valid.
- check_en=0 clears byte_count, done, fail and mismatch_index synchronously. The receiver is unaffected.

## Timing
- Reset values:
  - rx_valid, rx_frame_err, rx_parity_err, done, pass and fail are 0.
  - rx_data, byte_count and mismatch_index are 0.
  - The state is IDLE with armed=0.
- Define t0 as the cycle in which IDLE sees armed & rxd_s=0. That is 2–3 cycles after the rxd edge, because of the synchronizer.
- Samples are taken at:
  - start: t0+HALF;
  - data bit i: t0+HALF+(i+1)*DIV;
  - parity: t0+HALF+(DATA_BITS+1)*DIV;
  - stop k: after the data and parity slots, one DIV apart.
- rx_valid is asserted 1 cycle after the final stop sample and lasts exactly 1 cycle.
- Checker outputs (byte_count, done, fail, pass, mismatch_index) update 1 cycle after rx_valid.
- Back-to-back frames are accepted with zero idle bits. IDLE is re-entered before the next start edge, because the stop sample occurs at mid-bit.
- Reset asserted mid-frame aborts the frame with no rx_valid.
  - If rxd is low at release, armed=0 blocks a false start until rxd_s is high.

## Configuration
- UART_RX_MON_PARITY_EN defined: the PARITY state exists, one parity bit is expected after the data bits, and a mismatch drives rx_parity_err and fail.
- Not defined: no parity slot; the frame is start + DATA_BITS + STOP_BITS; rx_parity_err is tied to 0 and PARITY_ODD is ignored.

## Test plan
- Defaults (DIV=868), check_en=1, expected "Hello World from Efinix!" (24 chars, ending 'h21) driven at 115200 → 24 rx_valid pulses, byte_count=24, done=1, pass=1, fail=0.
- Same stimulus but char 6 sent as 'h77 instead of 'h57 → fail=1, mismatch_index=6, done=1 after '!', pass=0, and later chars are still reported.
- 200-cycle low glitch on rxd (< HALF) → no rx_valid; the receiver then accepts the next valid frame 'h48 correctly.
- Frame 'h55 with a stop bit of 0, then rxd held low for 20 bit times → one rx_valid with rx_frame_err=1 and fail=1, no further frames until rxd returns high, then the next frame is decoded.
- UART_RX_MON_PARITY_EN, PARITY_ODD=0, frame 'h48 with a parity bit of 1 (wrong) → rx_parity_err=1 and fail=1; with the correct parity bit 0 → no error.
- io_asyncResetn pulsed low mid-data-bit 4 while rxd is low → all outputs at reset values, no rx_valid; the next full frame 'h21 is decoded correctly.

Source files
------------

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: deserialises rxd and checks the byte stream against expected_data.
// Optional parity slot enabled by defining UART_RX_MON_PARITY_EN.
module uart_rx_monitor #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int MSG_LEN     = 24,
  parameter int TERM_CHAR   = 'h21,
  parameter bit PARITY_ODD  = 1'b0,
  localparam int CW         = $clog2(MSG_LEN + 1)
) (
  input  logic                         io_systemClk,
  input  logic                         io_asyncResetn,
  input  logic                         rxd,
  input  logic                         check_en,
  input  logic [MSG_LEN*DATA_BITS-1:0] expected_data,
  output logic                         rx_valid,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_frame_err,
  output logic                         rx_parity_err,
  output logic [CW-1:0]                byte_count,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [CW-1:0]                mismatch_index
);

  localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int BW   = $clog2(DIV);
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [BW-1:0]        HALF_M1  = BW'(HALF - 1);
  localparam logic [BW-1:0]        DIV_M1   = BW'(DIV - 1);
  localparam logic [IW-1:0]        LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]        LAST_STP = IW'(STOP_BITS - 1);
  localparam logic [DATA_BITS-1:0] TERM     = DATA_BITS'(TERM_CHAR);
  localparam logic [CW-1:0]        LEN      = CW'(MSG_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_MON_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_e;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  logic                 rxd_meta_q, rxd_s;
  logic [1:0]           fill_q;
  state_e               state_q;
  logic                 armed_q;
  logic [BW-1:0]        baud_cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q;
  logic                 slot_end, ferr_now;

  logic [CW-1:0]        byte_count_q, byte_count_d, mism_q, mism_d;
  logic                 done_q, done_d, fail_q, fail_d, pass_q;
  logic                 chk_err;

  assign slot_end = (baud_cnt_q == DIV_M1);
  assign ferr_now = frame_err_q | ~rxd_s;

  // fill_q delays arming after reset until rxd_s reflects the real line, not the reset value.
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      rxd_meta_q <= 1'b1;
      rxd_s      <= 1'b1;
      fill_q     <= 2'b00;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s      <= rxd_meta_q;
      fill_q     <= {fill_q[0], 1'b1};
    end
  end

`ifdef UART_RX_MON_PARITY_EN
  logic par_err_q, rx_parity_err_q;
  assign rx_parity_err = rx_parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
`ifdef UART_RX_MON_PARITY_EN
      par_err_q       <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rxd_s && fill_q[1]) armed_q <= 1'b1;
          if (armed_q && !rxd_s) begin
            state_q    <= S_START;
            baud_cnt_q <= '0;
          end
        end
        S_START: begin
          if (baud_cnt_q == HALF_M1) begin
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_MON_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            state_q     <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (slot_end) begin
            baud_cnt_q <= '0;
            shift_q    <= {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= '0;
`ifdef UART_RX_MON_PARITY_EN
              state_q   <= S_PARITY;
`else
              state_q   <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_MON_PARITY_EN
        S_PARITY: begin
          if (slot_end) begin
            baud_cnt_q <= '0;
            par_err_q  <= (rxd_s != calc_parity(shift_q));
            state_q    <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (slot_end) begin
            baud_cnt_q  <= '0;
            frame_err_q <= ferr_now;
            if (bit_idx_q == LAST_STP) begin
              rx_valid     <= 1'b1;
              rx_data      <= shift_q;
              rx_frame_err <= ferr_now;
`ifdef UART_RX_MON_PARITY_EN
              rx_parity_err_q <= par_err_q;
`endif
              state_q      <= ferr_now ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          armed_q <= 1'b0;
          if (rxd_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign chk_err = rx_frame_err | rx_parity_err |
                   (rx_data != expected_data[int'(byte_count_q)*DATA_BITS +: DATA_BITS]);

  always_comb begin
    byte_count_d = byte_count_q;
    done_d       = done_q;
    fail_d       = fail_q;
    mism_d       = mism_q;
    if (!check_en) begin
      byte_count_d = '0;
      done_d       = 1'b0;
      fail_d       = 1'b0;
      mism_d       = '0;
    end else if (rx_valid && !done_q) begin
      if (chk_err && !fail_q) begin
        fail_d = 1'b1;
        mism_d = byte_count_q;
      end else begin
        fail_d = fail_q;
      end
      byte_count_d = byte_count_q + 1'b1;
      if ((rx_data == TERM) || (byte_count_d == LEN)) done_d = 1'b1;
      else done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      byte_count_q <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      mism_q       <= '0;
      pass_q       <= 1'b0;
    end else begin
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      mism_q       <= mism_d;
      pass_q       <= done_d & ~fail_d;
    end
  end

  assign byte_count     = byte_count_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign pass           = pass_q;
  assign mismatch_index = mism_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed self-checking bench for uart_rx_monitor at a reduced divisor (DIV=16).
module tb_uart_rx_monitor;
  localparam int CLK_HZ = 1843200;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int MLEN   = 24;
  localparam int CW     = $clog2(MLEN + 1);
`ifdef UART_RX_MON_PARITY_EN
  localparam int PBITS  = 1;
`else
  localparam int PBITS  = 0;
`endif
  localparam int LAT    = 2 + HALF + (8 + PBITS + 1) * DIV + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxd = 1'b1;
  logic              check_en = 1'b0;
  logic [MLEN*8-1:0] exp_data = '0;
  logic              rx_valid, rx_frame_err, rx_parity_err, done, pass, fail;
  logic [7:0]        rx_data;
  logic [CW-1:0]     byte_count, mismatch_index;

  int n_checks = 0, n_pass = 0;
  int valid_cnt = 0, wide_pulse = 0;
  logic [7:0] rx_log [$];
  logic last_ferr = 1'b0, last_perr = 1'b0, prev_valid = 1'b0;
  string msg = "Hello World from Efinix!";

  uart_rx_monitor #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .STOP_BITS(1),
    .MSG_LEN(MLEN), .TERM_CHAR('h21), .PARITY_ODD(1'b0)
  ) dut (
    .io_systemClk(clk), .io_asyncResetn(rst_n), .rxd(rxd), .check_en(check_en),
    .expected_data(exp_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .byte_count(byte_count), .done(done), .pass(pass), .fail(fail),
    .mismatch_index(mismatch_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      rx_log.push_back(rx_data);
      last_ferr = rx_frame_err;
      last_perr = rx_parity_err;
    end
    if (rx_valid && prev_valid) wide_pulse++;
    prev_valid = rx_valid;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0h expected %0h", name, got, want);
    else n_pass++;
  endtask

  task automatic bit_time(input logic b);
    rxd = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_MON_PARITY_EN
    bit_time((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity slot");
`endif
    bit_time(stop_v);
  endtask

  task automatic clear_checker();
    check_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset frame_err", rx_frame_err, 0);
    chk("reset parity_err", rx_parity_err, 0);
    chk("reset byte_count", byte_count, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    chk("reset fail", fail, 0);
    chk("reset mismatch_index", mismatch_index, 0);
    rst_n = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int c = -1;
    bit seen = 1'b0;
    fork
      send_frame(8'h4B, 1'b1, 1'b0);
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (rx_valid) begin
            seen = 1'b1;
            c = k;
          end
        end
      end
    join
    chk("latency rx_valid cycle", c, LAT);
    chk("latency rx_data", rx_data, 8'h4B);
  endtask

  task automatic test_back_to_back();
    int v0, bad;
    clear_checker();
    v0 = valid_cnt;
    rx_log.delete();
    send_frame(8'(msg[0]), 1'b1, 1'b0);
    chk("b2b first byte_count", byte_count, 1);
    chk("b2b first done", done, 0);
    for (int j = 1; j < MLEN; j++) send_frame(8'(msg[j]), 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b valid count", valid_cnt - v0, MLEN);
    chk("b2b byte_count", byte_count, MLEN);
    chk("b2b done", done, 1);
    chk("b2b pass", pass, 1);
    chk("b2b fail", fail, 0);
    chk("b2b pulse width", wide_pulse, 0);
    bad = 0;
    for (int j = 0; j < MLEN && j < rx_log.size(); j++)
      if (rx_log[j] !== 8'(msg[j])) bad++;
    chk("b2b data stream errors", bad, 0);
  endtask

  task automatic test_mismatch();
    int v0;
    clear_checker();
    v0 = valid_cnt;
    rx_log.delete();
    for (int j = 0; j < 7; j++) send_frame((j == 6) ? 8'h77 : 8'(msg[j]), 1'b1, 1'b0);
    chk("mis early fail", fail, 1);
    chk("mis early done", done, 0);
    for (int j = 7; j < MLEN; j++) send_frame(8'(msg[j]), 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mis fail", fail, 1);
    chk("mis index", mismatch_index, 6);
    chk("mis done", done, 1);
    chk("mis pass", pass, 0);
    chk("mis valid count", valid_cnt - v0, MLEN);
    chk("mis last reported", (rx_log.size() > 0) ? rx_log[rx_log.size()-1] : 8'h00, 8'h21);
    send_frame(8'h41, 1'b1, 1'b0);
    chk("post-done byte_count", byte_count, MLEN);
    chk("post-done still reported", valid_cnt - v0, MLEN + 1);
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cnt;
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    chk("glitch no valid", valid_cnt - v0, 0);
    send_frame(8'h48, 1'b1, 1'b0);
    chk("glitch next valid", valid_cnt - v0, 1);
    chk("glitch next data", rx_data, 8'h48);
    chk("glitch next ferr", last_ferr, 0);
  endtask

  task automatic test_frame_error();
    int v0;
    clear_checker();
    v0 = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (20 * DIV) @(posedge clk);
    #1;
    chk("ferr one valid", valid_cnt - v0, 1);
    chk("ferr flag", last_ferr, 1);
    chk("ferr data", rx_data, 8'h55);
    chk("ferr fail", fail, 1);
    chk("ferr index", mismatch_index, 0);
    bit_time(1'b1);
    bit_time(1'b1);
    send_frame(8'h48, 1'b1, 1'b0);
    chk("ferr recover valid", valid_cnt - v0, 2);
    chk("ferr recover data", rx_data, 8'h48);
    chk("ferr recover flag", last_ferr, 0);
  endtask

  task automatic test_parity();
    clear_checker();
`ifdef UART_RX_MON_PARITY_EN
    send_frame(8'h48, 1'b1, 1'b1);
    chk("parity bad perr", last_perr, 1);
    chk("parity bad fail", fail, 1);
    clear_checker();
`endif
    send_frame(8'h48, 1'b1, 1'b0);
    chk("parity good perr", last_perr, 0);
    chk("parity good fail", fail, 0);
    chk("parity good byte_count", byte_count, 1);
  endtask

  task automatic test_reset_midframe();
    int v0;
    v0 = valid_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rxd = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst rx_valid", rx_valid, 0);
    chk("midrst rx_data", rx_data, 0);
    chk("midrst byte_count", byte_count, 0);
    chk("midrst fail", fail, 0);
    chk("midrst done", done, 0);
    rst_n = 1'b1;
    repeat (DIV - HALF - 3 + 3 * DIV) @(posedge clk);
    #1;
    bit_time(1'b1);
    bit_time(1'b1);
    chk("midrst no valid", valid_cnt - v0, 0);
    send_frame(8'h21, 1'b1, 1'b0);
    chk("midrst next valid", valid_cnt - v0, 1);
    chk("midrst next data", rx_data, 8'h21);
    chk("midrst next ferr", last_ferr, 0);
  endtask

  initial begin
    for (int j = 0; j < MLEN; j++) exp_data[j*8 +: 8] = 8'(msg[j]);
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_mismatch();
    test_glitch();
    test_frame_error();
    test_parity();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
